// File: rtl/sipo_framer.sv
// sipo_framer: MSB-first serial-to-parallel receiver with a valid/ready output word register.
// Define SIPO_FRAMER_PARITY_EN to append one even-parity bit per frame and report mismatches.
module sipo_framer #(
   parameter int SIZE = 8
) (
   input  logic            clk_in,
   input  logic            reset_n_in,
   input  logic            data_in,
   input  logic            frame_in,
   input  logic            ready_in,
   input  logic            clear_in,
   output logic [SIZE-1:0] r_data_out,
   output logic            r_valid_out,
   output logic            r_busy_out,
   output logic            r_abort_out,
   output logic            r_overrun_out,
   output logic            r_parity_err_out
);

`ifdef SIPO_FRAMER_PARITY_EN
   localparam int FRAME_BITS = SIZE + 1;
`else
   localparam int FRAME_BITS = SIZE;
`endif
   localparam int CW = $clog2(FRAME_BITS + 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d, shift_in;
   logic                  complete;
   logic                  abort;
   logic [SIZE-1:0]       word;
   logic                  word_perr;

   // shift_in already contains this cycle's bit, so a completing word is taken from it directly
   assign shift_in = {shift_q[FRAME_BITS-2:0], data_in};

`ifdef SIPO_FRAMER_PARITY_EN
   assign word      = shift_in[FRAME_BITS-1:1];
   assign word_perr = ^shift_in;
`else
   assign word      = shift_in;
   assign word_perr = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shift_d  = shift_q;
      complete = 1'b0;
      abort    = 1'b0;
      if (frame_in) begin
         shift_d = shift_in;
         if (count_q == CW'(FRAME_BITS - 1)) begin
            complete = 1'b1;
            count_d  = '0;
            state_d  = ST_IDLE;
         end else begin
            count_d = count_q + CW'(1);
            state_d = ST_SHIFT;
         end
      end else begin
         abort   = (state_q == ST_SHIFT);
         count_d = '0;
         shift_d = '0;
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q          <= ST_IDLE;
         count_q          <= '0;
         shift_q          <= '0;
         r_data_out       <= '0;
         r_valid_out      <= 1'b0;
         r_busy_out       <= 1'b0;
         r_abort_out      <= 1'b0;
         r_overrun_out    <= 1'b0;
         r_parity_err_out <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         shift_q     <= shift_d;
         r_busy_out  <= (count_d != '0);
         r_abort_out <= abort;

         if (clear_in)
            r_overrun_out <= 1'b0;

         // a new overrun is assigned after the clear so that it wins
         if (complete) begin
            if (!r_valid_out || ready_in) begin
               r_data_out       <= word;
               r_valid_out      <= 1'b1;
               r_parity_err_out <= word_perr;
            end else begin
               r_overrun_out <= 1'b1;
            end
         end else if (r_valid_out && ready_in) begin
            r_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: vector table, directed corner sequences and randomized traffic against a queue-based model.
// Honors SIPO_FRAMER_PARITY_EN to match the RTL build.
module tb_sipo_framer;

   localparam int SIZE = 8;
`ifdef SIPO_FRAMER_PARITY_EN
   localparam int FB  = SIZE + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FB  = SIZE;
   localparam bit PAR = 1'b0;
`endif

   logic            clk_in = 1'b0;
   logic            reset_n_in;
   logic            data_in, frame_in, ready_in, clear_in;
   logic [SIZE-1:0] r_data_out;
   logic            r_valid_out, r_busy_out, r_abort_out, r_overrun_out, r_parity_err_out;

   sipo_framer #(.SIZE(SIZE)) dut (
      .clk_in           (clk_in),
      .reset_n_in       (reset_n_in),
      .data_in          (data_in),
      .frame_in         (frame_in),
      .ready_in         (ready_in),
      .clear_in         (clear_in),
      .r_data_out       (r_data_out),
      .r_valid_out      (r_valid_out),
      .r_busy_out       (r_busy_out),
      .r_abort_out      (r_abort_out),
      .r_overrun_out    (r_overrun_out),
      .r_parity_err_out (r_parity_err_out)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   // reference model: bits collected so far in the current frame, plus output register contents
   bit              mq[$];
   logic [SIZE-1:0] m_data;
   bit              m_valid, m_abort, m_ov, m_perr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_abort = 1'b0;
      m_ov    = 1'b0;
      m_perr  = 1'b0;
   endtask

   task automatic model_edge(input bit d, input bit f, input bit r, input bit c);
      bit              done = 1'b0;
      bit              pe   = 1'b0;
      bit              nov  = m_ov;
      logic [SIZE-1:0] w    = '0;
      m_abort = 1'b0;
      if (c) nov = 1'b0;
      if (f) begin
         mq.push_back(d);
         if (mq.size() == FB) begin
            for (int unsigned k = 0; k < SIZE; k++) w = (w << 1) | SIZE'(mq[k]);
            if (PAR) for (int unsigned k = 0; k < FB; k++) pe = pe ^ mq[k];
            mq.delete();
            done = 1'b1;
         end
      end else begin
         if (mq.size() != 0) m_abort = 1'b1;
         mq.delete();
      end
      if (done) begin
         if (!m_valid || r) begin
            m_data  = w;
            m_valid = 1'b1;
            m_perr  = pe;
         end else begin
            nov = 1'b1;
         end
      end else if (m_valid && r) begin
         m_valid = 1'b0;
      end
      m_ov = nov;
   endtask

   task automatic check_all();
      chk("data",    r_data_out,       m_data);
      chk("valid",   r_valid_out,      m_valid);
      chk("busy",    r_busy_out,       mq.size() != 0);
      chk("abort",   r_abort_out,      m_abort);
      chk("overrun", r_overrun_out,    m_ov);
      chk("parity",  r_parity_err_out, m_perr);
   endtask

   task automatic step(input bit d, input bit f, input bit r, input bit c);
      data_in  = d;
      frame_in = f;
      ready_in = r;
      clear_in = c;
      @(posedge clk_in);
      model_edge(d, f, r, c);
      #1 check_all();
   endtask

   // sends one frame MSB first; ready_last raises ready_in only on the final sample
   task automatic send_word(input logic [SIZE-1:0] w, input bit par_flip, input bit ready_last);
      for (int unsigned k = 0; k < SIZE; k++)
         step(w[SIZE-1-k], 1'b1, ready_last && !PAR && (k == SIZE - 1), 1'b0);
      if (PAR) step((^w) ^ par_flip, 1'b1, ready_last, 1'b0);
   endtask

   typedef struct {
      bit              d, f, r;
      bit              e_valid, e_busy;
      logic [SIZE-1:0] e_data;
   } vec_t;

   vec_t tbl[FB+1];

   initial begin
      logic [SIZE-1:0] a5 = 8'hA5;

      for (int unsigned k = 0; k < FB; k++) begin
         tbl[k].d       = (k < SIZE) ? a5[SIZE-1-k] : 1'b0;
         tbl[k].f       = 1'b1;
         tbl[k].r       = 1'b0;
         tbl[k].e_valid = (k == FB - 1);
         tbl[k].e_busy  = (k != FB - 1);
         tbl[k].e_data  = (k == FB - 1) ? 8'hA5 : 8'h00;
      end
      tbl[FB] = '{d: 1'b0, f: 1'b0, r: 1'b1, e_valid: 1'b0, e_busy: 1'b0, e_data: 8'hA5};

      reset_n_in = 1'b0;
      data_in    = 1'b0;
      frame_in   = 1'b0;
      ready_in   = 1'b0;
      clear_in   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1 check_all();
      chk("reset_data", r_data_out, 0);
      @(negedge clk_in);
      reset_n_in = 1'b1;

      for (int unsigned i = 0; i < FB + 1; i++) begin
         step(tbl[i].d, tbl[i].f, tbl[i].r, 1'b0);
         chk("tbl_valid", r_valid_out, tbl[i].e_valid);
         chk("tbl_busy",  r_busy_out,  tbl[i].e_busy);
         chk("tbl_data",  r_data_out,  tbl[i].e_data);
      end

      send_word(8'h3C, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0);
      chk("ovr_data", r_data_out, 8'h3C);
      chk("ovr_flag", r_overrun_out, 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_clear", r_overrun_out, 0);

      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_word(8'h11, 1'b0, 1'b0);
      chk("sim_first", r_data_out, 8'h11);
      send_word(8'h22, 1'b0, 1'b1);
      chk("sim_data",  r_data_out, 8'h22);
      chk("sim_valid", r_valid_out, 1);
      chk("sim_ovr",   r_overrun_out, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      send_word(8'h5A, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_hi",    r_abort_out, 1);
      chk("abort_busy",  r_busy_out, 0);
      chk("abort_valid", r_valid_out, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_lo", r_abort_out, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_word(8'hFF, 1'b0, 1'b0);
      chk("after_abort", r_data_out, 8'hFF);
      step(1'b0, 1'b0, 1'b1, 1'b0);

      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset_n_in = 1'b0;
      model_reset();
      #1 check_all();
      chk("rst_busy", r_busy_out, 0);
      frame_in = 1'b0;
      @(negedge clk_in);
      reset_n_in = 1'b1;
      send_word(8'h81, 1'b0, 1'b0);
      chk("rst_word", r_data_out, 8'h81);
      step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_FRAMER_PARITY_EN
      send_word(8'hA5, 1'b0, 1'b0);
      chk("par_ok", r_parity_err_out, 0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_word(8'hA5, 1'b1, 1'b0);
      chk("par_err",  r_parity_err_out, 1);
      chk("par_data", r_data_out, 8'hA5);
      step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

      for (int unsigned n = 0; n < 3000; n++)
         step($urandom_range(1, 0) == 1, $urandom_range(7, 0) != 0,
              $urandom_range(2, 0) == 0, $urandom_range(15, 0) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
